// File: rtl/lap_stopwatch_pkg.sv
//==============================================================================
// Module : lap_stopwatch_pkg
// Brief  : Digit-base limits, mode encoding and BCD pair sanitiser.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package lap_stopwatch_pkg;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 99;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Pair index 0 is centiseconds, then seconds, minutes, hours.
    function automatic int pair_max(input int idx);
        case (idx)
            0:       return CS_MAX;
            1:       return SEC_MAX;
            2:       return MIN_MAX;
            default: return HR_MAX;
        endcase
    endfunction

    // A tens digit beyond the base saturates the whole pair to its maximum.
    function automatic logic [7:0] sanitize_pair(input logic [7:0] pair, input int lim);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = pair[7:4];
        units = pair[3:0];
        if (tens > 4'(lim / 10)) begin
            return {4'(lim / 10), 4'(lim % 10)};
        end
        if (units > 4'd9) begin
            units = 4'd9;
        end
        return {tens, units};
    endfunction

endpackage

`default_nettype wire

// File: rtl/lap_stopwatch_bcd_pair_counter.sv
//==============================================================================
// Module : bcd_pair_counter
// Brief  : Two-digit BCD up/down counter wrapping at MAX with ripple outputs.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module bcd_pair_counter
    import lap_stopwatch_pkg::*;
#(
    parameter int MAX = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_out,
    output logic       borrow_out
);

    localparam logic [7:0] C_MAX_BCD = {4'(MAX / 10), 4'(MAX % 10)};

    logic [7:0] value_q;
    logic [7:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = sanitize_pair(load_val, MAX);
        end else if (en) begin
            if (dir == MODE_UP) begin
                if (value_q == C_MAX_BCD) begin
                    value_d = 8'h00;
                end else if (value_q[3:0] == 4'd9) begin
                    value_d = {value_q[7:4] + 4'd1, 4'd0};
                end else begin
                    value_d = {value_q[7:4], value_q[3:0] + 4'd1};
                end
            end else begin
                if (value_q == 8'h00) begin
                    value_d = C_MAX_BCD;
                end else if (value_q[3:0] == 4'd0) begin
                    value_d = {value_q[7:4] - 4'd1, 4'd9};
                end else begin
                    value_d = {value_q[7:4], value_q[3:0] - 4'd1};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= 8'h00;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = en && (dir == MODE_UP)   && (value_q == C_MAX_BCD);
    assign borrow_out = en && (dir == MODE_DOWN) && (value_q == 8'h00);

endmodule

`default_nettype wire

// File: rtl/lap_stopwatch.sv
//==============================================================================
// Module : lap_stopwatch
// Brief  : Up/down BCD stopwatch with preset load and circular lap buffer.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module lap_stopwatch
    import lap_stopwatch_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TICK_HZ    = 100,
    parameter int NUM_DIGITS = 8,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             clear,
    input  logic                             mode,
    input  logic                             load,
    input  logic [4*NUM_DIGITS-1:0]          preset_data,
    input  logic                             lap,
    input  logic                             lap_pop,
    output logic [4*NUM_DIGITS-1:0]          time_data,
    output logic                             running,
    output logic                             done,
    output logic [4*NUM_DIGITS-1:0]          lap_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_cnt,
    output logic                             lap_empty,
    output logic                             lap_full,
    output logic                             lap_ovf
);

    localparam int C_DIV     = CLK_FREQ / TICK_HZ;
    localparam int C_PRESC_W = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int C_PAIRS   = NUM_DIGITS / 2;
    localparam int C_TW      = 4 * NUM_DIGITS;
    localparam int C_PTR_W   = $clog2(LAP_DEPTH);
    localparam int C_CNT_W   = $clog2(LAP_DEPTH + 1);

    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(C_DIV - 1);
    localparam logic [C_TW-1:0]      C_TIME_ONE  = C_TW'(1);
    localparam logic [C_PTR_W-1:0]   C_PTR_LAST  = C_PTR_W'(LAP_DEPTH - 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_FULL  = C_CNT_W'(LAP_DEPTH);

    logic [C_PRESC_W-1:0] presc_q, presc_d;
    logic                 halted_q, halted_d;
    logic                 mode_q;
    logic                 done_q;
    logic                 running_q;

    logic                 w_count_en;
    logic                 w_tick;
    logic                 w_reach_zero;
    logic                 w_load_pair;
    logic [C_TW-1:0]      w_load_val;
    logic [C_PAIRS:0]     w_ripple;
    logic                 w_unused_top_ripple;

    always_comb begin
        w_count_en   = start && !halted_q;
        // A countdown sitting at zero never ticks, so no wrap to all-nines.
        w_tick       = w_count_en && (presc_q == C_PRESC_MAX) && !clear && !load &&
                       !((mode == MODE_DOWN) && (time_data == '0));
        w_reach_zero = w_tick && (mode == MODE_DOWN) && (time_data == C_TIME_ONE);

        presc_d = presc_q;
        if (clear || load) begin
            presc_d = '0;
        end else if (w_count_en) begin
            presc_d = (presc_q == C_PRESC_MAX) ? '0 : presc_q + 1'b1;
        end

        halted_d = halted_q;
        if (clear || load || (mode != mode_q)) begin
            halted_d = 1'b0;
        end else if (w_reach_zero) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            halted_q  <= 1'b0;
            mode_q    <= MODE_UP;
            done_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            halted_q  <= halted_d;
            mode_q    <= mode;
            done_q    <= w_reach_zero;
            running_q <= start && !halted_d;
        end
    end

    // Clear reuses the pair load path with a zero value.
    assign w_load_pair = clear || load;
    assign w_load_val  = clear ? '0 : preset_data;
    assign w_ripple[0] = w_tick;

    generate
        for (genvar i = 0; i < C_PAIRS; i++) begin : g_pair
            logic w_carry;
            logic w_borrow;

            bcd_pair_counter #(
                .MAX (pair_max(i))
            ) u_pair (
                .clk        (clk),
                .rst_n      (rst_n),
                .en         (w_ripple[i]),
                .dir        (mode),
                .load       (w_load_pair),
                .load_val   (w_load_val[8*i +: 8]),
                .value      (time_data[8*i +: 8]),
                .carry_out  (w_carry),
                .borrow_out (w_borrow)
            );

            assign w_ripple[i+1] = w_carry || w_borrow;
        end
    endgenerate

    assign w_unused_top_ripple = w_ripple[C_PAIRS];

    logic [C_TW-1:0]    lap_mem_q [LAP_DEPTH];
    logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_CNT_W-1:0] lap_cnt_q;
    logic               lap_ovf_q;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;

    function automatic logic [C_PTR_W-1:0] next_ptr(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty = (lap_cnt_q == '0);
    assign w_full  = (lap_cnt_q == C_CNT_FULL);
    assign w_push  = lap && !clear;
    assign w_pop   = lap_pop && !clear && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            lap_mem_q[wr_ptr_q] <= time_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lap_cnt_q <= '0;
            lap_ovf_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            lap_cnt_q <= '0;
            lap_ovf_q <= 1'b0;
        end else if (w_push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
            if (w_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end else if (w_full) begin
                rd_ptr_q  <= next_ptr(rd_ptr_q);
                lap_ovf_q <= 1'b1;
            end else begin
                lap_cnt_q <= lap_cnt_q + 1'b1;
            end
        end else if (w_pop) begin
            rd_ptr_q  <= next_ptr(rd_ptr_q);
            lap_cnt_q <= lap_cnt_q - 1'b1;
        end
    end

    assign running   = running_q;
    assign done      = done_q;
    assign lap_data  = w_empty ? '0 : lap_mem_q[rd_ptr_q];
    assign lap_cnt   = lap_cnt_q;
    assign lap_empty = w_empty;
    assign lap_full  = w_full;
    assign lap_ovf   = lap_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lap_stopwatch.sv
//==============================================================================
// Module : tb_lap_stopwatch
// Brief  : Directed self-checking bench for lap_stopwatch (tick every 10 clocks).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_lap_stopwatch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear;
    logic        mode;
    logic        load;
    logic [31:0] preset_data;
    logic        lap;
    logic        lap_pop;
    logic [31:0] time_data;
    logic        running;
    logic        done;
    logic [31:0] lap_data;
    logic [2:0]  lap_cnt;
    logic        lap_empty;
    logic        lap_full;
    logic        lap_ovf;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;

    lap_stopwatch #(
        .CLK_FREQ   (1000),
        .TICK_HZ    (100),
        .NUM_DIGITS (8),
        .LAP_DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .clear       (clear),
        .mode        (mode),
        .load        (load),
        .preset_data (preset_data),
        .lap         (lap),
        .lap_pop     (lap_pop),
        .time_data   (time_data),
        .running     (running),
        .done        (done),
        .lap_data    (lap_data),
        .lap_cnt     (lap_cnt),
        .lap_empty   (lap_empty),
        .lap_full    (lap_full),
        .lap_ovf     (lap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] val);
        preset_data = val;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    logic [31:0] san_in  [4];
    logic [31:0] san_exp [4];
    logic        run_ok;

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = 1'b0;
        load = 1'b0; preset_data = '0; lap = 1'b0; lap_pop = 1'b0;
        step(3);
        check_val("rst_time",      time_data, 32'h0);
        check_val("rst_running",   32'(running), 32'h0);
        check_val("rst_done",      32'(done), 32'h0);
        check_val("rst_lap_cnt",   32'(lap_cnt), 32'h0);
        check_val("rst_lap_empty", 32'(lap_empty), 32'h1);
        check_val("rst_lap_full",  32'(lap_full), 32'h0);
        check_val("rst_lap_ovf",   32'(lap_ovf), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Up count: 1000 clocks = 100 ticks = 1.00 s
        start  = 1'b1;
        run_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            if (running !== 1'b1) run_ok = 1'b0;
        end
        check_val("up_running_all", 32'(run_ok), 32'h1);
        check_val("up_time_1s", time_data, 32'h0000_0100);
        start = 1'b0;
        step(1);
        check_val("pause_running", 32'(running), 32'h0);
        step(50);
        check_val("pause_hold", time_data, 32'h0000_0100);

        // Wrap at 99:59:59.99
        do_load(32'h9959_5999);
        check_val("wrap_loaded", time_data, 32'h9959_5999);
        start = 1'b1;
        step(9);
        check_val("wrap_before_tick", time_data, 32'h9959_5999);
        step(1);
        check_val("wrap_zero", time_data, 32'h0);
        start = 1'b0;
        check_val("wrap_no_done", 32'(done_seen), 32'h0);

        // Countdown from 0.03
        mode = 1'b1;
        do_load(32'h0000_0003);
        start = 1'b1;
        step(29);
        check_val("down_one_left", time_data, 32'h0000_0001);
        check_val("down_done_early", 32'(done_seen), 32'h0);
        step(1);
        check_val("down_zero", time_data, 32'h0);
        check_val("down_done_pulse", 32'(done), 32'h1);
        check_val("down_halt_run", 32'(running), 32'h0);
        step(1);
        check_val("down_done_1cyc", 32'(done), 32'h0);
        step(100);
        check_val("down_hold_zero", time_data, 32'h0);
        check_val("down_hold_run", 32'(running), 32'h0);
        check_val("down_done_count", 32'(done_seen), 32'h1);
        start = 1'b0;

        // Borrow across fields, then sanitised loads
        do_load(32'h0001_0000);
        start = 1'b1;
        step(10);
        start = 1'b0;
        check_val("borrow_fields", time_data, 32'h0000_5999);
        san_in[0] = 32'h00AB_7C12; san_exp[0] = 32'h0059_5912;
        san_in[1] = 32'hAB00_0000; san_exp[1] = 32'h9900_0000;
        san_in[2] = 32'h0000_3C3C; san_exp[2] = 32'h0000_3939;
        san_in[3] = 32'h1234_5678; san_exp[3] = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            do_load(san_in[i]);
            check_val($sformatf("sanitize_%0d", i), time_data, san_exp[i]);
        end

        // Down mode entered at zero: no counting, no done
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        start = 1'b1;
        step(30);
        start = 1'b0;
        check_val("zero_down_time", time_data, 32'h0);
        check_val("zero_down_nodone", 32'(done_seen), 32'h1);

        // Lap buffer: five laps into depth four
        mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            do_load(32'(k));
            lap = 1'b1;
            step(1);
            lap = 1'b0;
            if (k == 4) begin
                check_val("lap4_cnt",  32'(lap_cnt), 32'h4);
                check_val("lap4_full", 32'(lap_full), 32'h1);
                check_val("lap4_ovf",  32'(lap_ovf), 32'h0);
                check_val("lap4_head", lap_data, 32'h1);
            end
        end
        check_val("lap5_cnt",  32'(lap_cnt), 32'h4);
        check_val("lap5_full", 32'(lap_full), 32'h1);
        check_val("lap5_ovf",  32'(lap_ovf), 32'h1);
        check_val("lap5_head", lap_data, 32'h2);
        lap = 1'b1; lap_pop = 1'b1;
        step(1);
        lap = 1'b0; lap_pop = 1'b0;
        check_val("pushpop_cnt",  32'(lap_cnt), 32'h4);
        check_val("pushpop_head", lap_data, 32'h3);
        for (int i = 0; i < 4; i++) begin
            lap_pop = 1'b1;
            step(1);
            lap_pop = 1'b0;
        end
        check_val("drain_empty", 32'(lap_empty), 32'h1);
        check_val("drain_data",  lap_data, 32'h0);
        check_val("drain_full",  32'(lap_full), 32'h0);
        lap_pop = 1'b1;
        step(1);
        lap_pop = 1'b0;
        check_val("pop_empty_cnt", 32'(lap_cnt), 32'h0);
        check_val("ovf_sticky", 32'(lap_ovf), 32'h1);

        // Priority: clear beats load and lap
        do_load(32'h0000_0012);
        lap = 1'b1;
        step(2);
        lap = 1'b0;
        check_val("prio_pre_cnt", 32'(lap_cnt), 32'h2);
        clear = 1'b1; load = 1'b1; lap = 1'b1; preset_data = 32'h0000_1234;
        step(1);
        clear = 1'b0; load = 1'b0; lap = 1'b0;
        check_val("prio_time", time_data, 32'h0);
        check_val("prio_cnt",  32'(lap_cnt), 32'h0);
        check_val("prio_ovf",  32'(lap_ovf), 32'h0);
        do_load(32'h0000_0012);
        preset_data = 32'h0000_0077; load = 1'b1; lap = 1'b1;
        step(1);
        load = 1'b0; lap = 1'b0;
        check_val("loadlap_time", time_data, 32'h0000_0077);
        check_val("loadlap_head", lap_data, 32'h0000_0012);
        check_val("loadlap_cnt",  32'(lap_cnt), 32'h1);

        // Asynchronous reset mid-count
        start = 1'b1;
        step(15);
        check_val("midcount_time", time_data, 32'h0000_0078);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_time",    time_data, 32'h0);
        check_val("arst_running", 32'(running), 32'h0);
        check_val("arst_done",    32'(done), 32'h0);
        check_val("arst_cnt",     32'(lap_cnt), 32'h0);
        check_val("arst_empty",   32'(lap_empty), 32'h1);
        check_val("arst_data",    lap_data, 32'h0);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
- Parametrised next-generation stopwatch/timer core for the 7-segment clock design.
- Generalises the fixed up-counting stopwatch: configurable tick rate, 6- or 8-digit BCD format, up/down (countdown) mode with preset load, and a LAP_DEPTH-entry lap capture buffer.
- Sits between key_ctrl (start/clear/lap pulses) and max7219_ctrl, which consumes time_data or lap_data.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- TICK_HZ, 100: count resolution in Hz; the least significant digit pair counts centiseconds. CLK_FREQ must be divisible by TICK_HZ.
- NUM_DIGITS, 8: 8 gives HH:MM:SS:cc (HH 00-99); 6 gives MM:SS:cc. No other values are legal.
- LAP_DEPTH, 4: number of lap entries; must be ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level input: count while 1, pause while 0.
- clear  in  1  one-cycle pulse: zero the time, empty the lap buffer, clear lap_ovf.
- mode  in  1  0 = count up, 1 = count down.
- load  in  1  one-cycle pulse: time ← preset_data.
- preset_data  in  4*NUM_DIGITS  packed BCD preset; the least significant nibble is cs units.
- lap  in  1  one-cycle pulse: push the current time into the lap buffer.
- lap_pop  in  1  one-cycle pulse: discard the head entry.
- time_data  out  4*NUM_DIGITS  live packed BCD time.
- running  out  1  high while start=1 and the counter is not halted.
- done  out  1  one-cycle pulse when a countdown reaches zero.
- lap_data  out  4*NUM_DIGITS  oldest stored lap; all zeros when the buffer is empty.
- lap_cnt  out  $clog2(LAP_DEPTH+1)  number of stored laps.
- lap_empty  out  1  lap_cnt == 0.
- lap_full  out  1  lap_cnt == LAP_DEPTH.
- lap_ovf  out  1  sticky flag: a lap entry was overwritten.

Behaviour:
- Reset: all outputs 0, lap_empty = 1, prescaler 0, halted = 0.
- Prescaler: counts 0..CLK_FREQ/TICK_HZ-1 while running. The terminal count produces a one-cycle internal tick. The prescaler holds while paused and is zeroed on clear or load.
- Tick updates time_data on the same edge; time_data is registered and has no further latency.
- Digit bases: cc 0-99, SS 0-59, MM 0-59, HH 0-99. Carry and borrow ripple combinationally within the cycle.
- Up mode: 99:59:59.99 (or 59:59.99 when NUM_DIGITS = 6) wraps to zero. done stays low and counting continues.
- Down mode: a tick at all-zero never occurs. On the tick that reaches zero, done pulses in the same cycle time_data becomes zero, and halted is set.
- Halted: ticks are suppressed and running = 0. halted is cleared by clear, load, or any change of mode.
- Down mode entered with time = 0: no counting and no done pulse.
- Priority in one cycle: clear > load > tick. A lap in the same cycle as clear is discarded. A lap with load captures the pre-load value.
- load sanitises invalid digits: a tens digit above the base limit (e.g. 7 in SS tens) clamps to the maximum legal value; units > 9 clamp to 9.
- mode may change at any time. The direction takes effect on the next tick; no other state changes.
- Lap buffer: circular, with wr_ptr, rd_ptr and count. lap captures time_data as registered in that cycle, i.e. the value before any same-cycle tick update.
- Push when full, no pop: overwrite the oldest entry, advance rd_ptr, keep count, set lap_ovf.
- Push and pop together, non-empty: both occur and count is unchanged. Push and pop together, empty: push only.
- Pop when empty: ignored.
- lap_data, lap_cnt and the flags update on the edge after a push or pop.
- Reset mid-count: everything returns to reset values immediately (asynchronous).

Decomposition:
- Package lap_stopwatch_pkg contains:
  - digit-base constants (CS_MAX = 99, SEC_MAX = 59, MIN_MAX = 59, HR_MAX = 99);
  - the mode encoding (MODE_UP, MODE_DOWN);
  - a function sanitising one BCD pair against a base limit.
- One sub-module, bcd_pair_counter, parameterised by MAX. Inputs: en, dir, load, load_val. Outputs: value[7:0] and carry_out/borrow_out. It is instantiated NUM_DIGITS/2 times and chained.

Test Plan:
(Sim parameters for all scenarios: CLK_FREQ = 1000, TICK_HZ = 100, so one tick every 10 cycles.)
1. Up count: start = 1 for 1000 cycles → time_data = 0x00000100; running = 1 throughout. Drop start → value holds and running = 0.
2. Wrap: load 0x99595999, up mode, one tick → 0x00000000; done stays 0.
3. Countdown: load 0x00000003, mode = 1, start = 1 → after 3 ticks time = 0, one-cycle done, running = 0. Hold 100 more cycles → time stays 0.
4. Carry/borrow across fields: load 0x00010000, down mode, one tick → 0x00005999. Load preset 0x00AB7C12 → sanitised to 0x00595912.
5. Lap buffer, LAP_DEPTH = 4: five laps at times 1, 2, 3, 4, 5 → lap_full = 1, lap_ovf = 1, lap_data = time 2. Simultaneous lap + lap_pop → lap_cnt stays 4. Four pops → lap_empty = 1, lap_data = 0.
6. Priority: clear + load + lap in the same cycle → time = 0, lap_cnt = 0, lap_ovf = 0. Assert rst_n low mid-count → all outputs 0 asynchronously.
